// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle MIPS controller.
// Holds the 4-bit FSM state enum, opcode and funct constants, the ALU
// control codes, and the aluSrcB / pcSrc mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_MUL = 3'b011;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: combinational ALU control decode.
// Ports: funct_i (R-type funct), is_rtype_i (decode funct when 1),
//        force_op_i (code passed through when is_rtype_i=0),
//        alu_control_o (3-bit ALU op), unsupported_o (funct not handled).
// Build option: MC_MUL_EN adds funct 011000 -> multiply.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic       is_rtype_i,
  input  logic [2:0] force_op_i,
  output logic [2:0] alu_control_o,
  output logic       unsupported_o
);

  // Funct lookup for R-type execute; other states pass their own op through.
  always_comb begin
    alu_control_o = ALU_ADD;
    unsupported_o = 1'b0;
    if (is_rtype_i) begin
      case (funct_i)
        FN_ADD:  alu_control_o = ALU_ADD;
        FN_SUB:  alu_control_o = ALU_SUB;
        FN_AND:  alu_control_o = ALU_AND;
        FN_OR:   alu_control_o = ALU_OR;
        FN_SLT:  alu_control_o = ALU_SLT;
`ifdef MC_MUL_EN
        FN_MUL:  alu_control_o = ALU_MUL;
`endif
        default: unsupported_o = 1'b1;
      endcase
    end else begin
      alu_control_o = force_op_i;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the multicycle MIPS datapath.
// Inputs : clk, reset (async, active-high), op, funct, zero.
// Outputs: datapath strobes (pcWrite, irWrite, memWrite, regWrite),
//          mux selects (iOrD, regDst, memToReg, aluSrcA, aluSrcB, pcSrc),
//          aluControl, illegal pulse, and the debug state.
// Build option: MC_MUL_EN enables funct 011000 (multiply), holding
// RTYPEEX for 1+MUL_LAT cycles.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       iOrD,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [2:0] aluControl,
  output logic       illegal,
  output logic [3:0] state
);

  if ((MUL_LAT < 1) || (MUL_LAT > 7)) begin : g_bad_mul_lat
    $error("mc_controller: MUL_LAT must be 1..7");
  end

  state_e     state_q, state_d;
  logic       pc_write_s, ir_write_s, mem_write_s, reg_write_s, illegal_s;
  logic       is_rtype_s, dec_unsup_s;
  logic [2:0] force_op_s, dec_alu_s;

`ifdef MC_MUL_EN
  localparam logic [2:0] MUL_LOAD = 3'(MUL_LAT);
  logic [2:0] mul_cnt_q, mul_cnt_d;
  logic       is_mul_s;
  assign is_mul_s = (funct == FN_MUL);
`endif

  alu_decoder u_alu_decoder (
    .funct_i       (funct),
    .is_rtype_i    (is_rtype_s),
    .force_op_i    (force_op_s),
    .alu_control_o (dec_alu_s),
    .unsupported_o (dec_unsup_s)
  );

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MC_MUL_EN
  // Multiply hold counter: loaded entering RTYPEEX, counts down while held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_cnt_q <= 3'd0;
    end else begin
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Counter next value.
  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if ((state_q == S_DECODE) && (op == OP_RTYPE)) begin
      mul_cnt_d = MUL_LOAD;
    end else if ((state_q == S_RTYPEEX) && (mul_cnt_q != 3'd0)) begin
      mul_cnt_d = mul_cnt_q - 3'd1;
    end else begin
      mul_cnt_d = mul_cnt_q;
    end
  end
`endif

  // Next-state and Moore output decode.
  always_comb begin
    state_d     = S_FETCH;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    iOrD        = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REGB;
    pcSrc       = PCSRC_ALU;
    force_op_s  = ALU_ADD;
    is_rtype_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        aluSrcB    = SRCB_FOUR;
        pc_write_s = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut.
        aluSrcB = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iOrD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memToReg    = 1'b1;
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        iOrD        = 1'b1;
        mem_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_RTYPEEX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = SRCB_REGB;
        is_rtype_s = 1'b1;
        if (dec_unsup_s) begin
          illegal_s = 1'b1;
          state_d   = S_FETCH;
        end else begin
`ifdef MC_MUL_EN
          state_d = (is_mul_s && (mul_cnt_q != 3'd0)) ? S_RTYPEEX : S_RTYPEWB;
`else
          state_d = S_RTYPEWB;
`endif
        end
      end
      S_RTYPEWB: begin
        regDst      = 1'b1;
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQEX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = SRCB_REGB;
        force_op_s = ALU_SUB;
        pcSrc      = PCSRC_ALUOUT;
        pc_write_s = zero;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_JEX: begin
        pcSrc      = PCSRC_JUMP;
        pc_write_s = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are suppressed for as long as reset is held.
  assign pcWrite    = pc_write_s  & ~reset;
  assign irWrite    = ir_write_s  & ~reset;
  assign memWrite   = mem_write_s & ~reset;
  assign regWrite   = reg_write_s & ~reset;
  assign illegal    = illegal_s   & ~reset;
  assign aluControl = dec_alu_s;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: an instruction-level model expands
// each instruction into its expected per-cycle output records; a compare
// process checks the DUT against them every cycle.
module tb_mc_controller;
  import mc_pkg::*;

  localparam int MUL_LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcWrite, irWrite, memWrite, regWrite, iOrD, regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic [2:0] aluControl;
  logic       illegal;
  logic [3:0] state;

  mc_controller #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcWrite(pcWrite), .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite),
    .iOrD(iOrD), .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluControl(aluControl), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, memw, regw, iord, regdst, m2r, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  exp_t seq[$];
  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, got, want);
  endtask

  function automatic exp_t blank(input state_e s);
    exp_t r;
    r     = '0;
    r.st  = s;
    r.alu = 3'b010;
    return r;
  endfunction

  // R-type funct table: returns {supported, alu code}.
  function automatic logic [3:0] rtype_code(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
`ifdef MC_MUL_EN
      6'b011000: return {1'b1, 3'b011};
`endif
      default:   return {1'b0, 3'b010};
    endcase
  endfunction

  // Expand one instruction into its expected cycle records.
  task automatic build_seq(input logic [5:0] o, input logic [5:0] f, input logic z);
    exp_t r;
    logic [3:0] rc;
    int hold;
    seq.delete();
    r = blank(S_FETCH); r.irw = 1'b1; r.srcb = 2'b01; r.pcw = 1'b1; seq.push_back(r);
    r = blank(S_DECODE); r.srcb = 2'b11;
    r.ill = !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
    seq.push_back(r);
    case (o)
      6'b100011: begin
        r = blank(S_MEMADR); r.srca = 1'b1; r.srcb = 2'b10; seq.push_back(r);
        r = blank(S_MEMRD);  r.iord = 1'b1; seq.push_back(r);
        r = blank(S_MEMWB);  r.m2r = 1'b1; r.regw = 1'b1; seq.push_back(r);
      end
      6'b101011: begin
        r = blank(S_MEMADR); r.srca = 1'b1; r.srcb = 2'b10; seq.push_back(r);
        r = blank(S_MEMWR);  r.iord = 1'b1; r.memw = 1'b1; seq.push_back(r);
      end
      6'b000000: begin
        rc   = rtype_code(f);
        hold = (f == 6'b011000 && rc[3]) ? 1 + MUL_LAT : 1;
        for (int k = 0; k < hold; k++) begin
          r = blank(S_RTYPEEX); r.srca = 1'b1; r.alu = rc[2:0]; r.ill = !rc[3];
          seq.push_back(r);
        end
        if (rc[3]) begin
          r = blank(S_RTYPEWB); r.regdst = 1'b1; r.regw = 1'b1; seq.push_back(r);
        end
      end
      6'b000100: begin
        r = blank(S_BEQEX); r.srca = 1'b1; r.alu = 3'b110; r.pcsrc = 2'b01; r.pcw = z;
        seq.push_back(r);
      end
      6'b001000: begin
        r = blank(S_ADDIEX); r.srca = 1'b1; r.srcb = 2'b10; seq.push_back(r);
        r = blank(S_ADDIWB); r.regw = 1'b1; seq.push_back(r);
      end
      6'b000010: begin
        r = blank(S_JEX); r.pcsrc = 2'b10; r.pcw = 1'b1; seq.push_back(r);
      end
      default: ;
    endcase
  endtask

  // Drive n cycles of an instruction starting at a negedge in FETCH.
  task automatic run_cycles(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
    build_seq(o, f, z);
    op = o; funct = f; zero = z;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(seq[i]);
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    build_seq(o, f, z);
    run_cycles(o, f, z, seq.size());
    @(negedge clk);
  endtask

  // Compare process: DUT outputs against the next expected record.
  always @(negedge clk) begin
    exp_t e, a;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: state, pcw: pcWrite, irw: irWrite, memw: memWrite, regw: regWrite,
            iord: iOrD, regdst: regDst, m2r: memToReg, srca: aluSrcA, srcb: aluSrcB,
            pcsrc: pcSrc, alu: aluControl, ill: illegal};
      chk($sformatf("cycle_st%0d", e.st), 32'(a), 32'(e));
    end
  end

  localparam logic [5:0] R_FUNCTS [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

  initial begin
    logic [5:0] ro, rf;
    int sel;
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

    // Hand-computed pins on the model itself.
    build_seq(6'b100011, 6'd0, 1'b0);
    chk("model_lw_len", seq.size(), 5);
    chk("model_lw_c5", {seq[4].regw, seq[4].m2r, seq[3].iord}, 3'b111);
    build_seq(6'b000100, 6'd0, 1'b1);
    chk("model_beq_c3", {seq.size() == 3, seq[2].pcw, seq[2].pcsrc, seq[2].alu}, {1'b1, 1'b1, 2'b01, 3'b110});
    build_seq(6'b111111, 6'd0, 1'b0);
    chk("model_illop", {seq.size() == 2, seq[1].ill}, 2'b11);
    build_seq(6'b000000, 6'b000111, 1'b0);
    chk("model_illfn_len", seq.size(), 3);
    build_seq(6'b000000, 6'b011000, 1'b0);
`ifdef MC_MUL_EN
    chk("model_mul_len", seq.size(), 6);
`else
    chk("model_mul_len", seq.size(), 3);
`endif

    @(negedge clk); @(negedge clk);
    chk("rst_state", state, S_FETCH);
    chk("rst_strobes", {pcWrite, irWrite, memWrite, regWrite, illegal}, 5'b0);
    reset = 1'b0;

    // lw interrupted by reset in MEMRD.
    run_cycles(6'b100011, 6'd0, 1'b0, 4);
    #3 reset = 1'b1;
    #1 chk("midrst_state", state, S_FETCH);
    chk("midrst_regwrite", regWrite, 1'b0);
    @(negedge clk);
    chk("rsthold_state", state, S_FETCH);
    chk("rsthold_strobes", {pcWrite, irWrite, memWrite, regWrite, illegal, aluSrcB, aluControl},
        {5'b0, 2'b01, 3'b010});
    reset = 1'b0;

    run_instr(6'b100011, 6'd0, 1'b0);
    run_instr(6'b101011, 6'd0, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b1);
    run_instr(6'b000100, 6'd0, 1'b0);
    foreach (R_FUNCTS[i]) run_instr(6'b000000, R_FUNCTS[i], 1'b0);
    run_instr(6'b001000, 6'd0, 1'b0);
    run_instr(6'b000010, 6'd0, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b0);
    run_instr(6'b000000, 6'b000111, 1'b0);
    run_instr(6'b000000, 6'b011000, 1'b0);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 7);
      ro  = (sel < 6) ? OPS[sel] : 6'($urandom_range(0, 63));
      sel = $urandom_range(0, 7);
      rf  = (sel < 5) ? R_FUNCTS[sel] : ((sel == 5) ? 6'b011000 : 6'($urandom_range(0, 63)));
      run_instr(ro, rf, 1'($urandom_range(0, 1)));
    end

    @(negedge clk); @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
